// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Exhaustive truth-table checker for a combinational gate. Applies every
//   input vector 0 .. 2**N_IN-1 in ascending order, waits SETTLE cycles,
//   samples the gate output and compares it with TRUTH[vector].
//
//   Optional build macro: GATE_CHK_STOP_ON_FAIL_EN
//     defined     -> the first mismatch ends the run immediately.
//     not defined -> every vector is applied; err_count totals mismatches.
//
// Parameters
//   N_IN    number of gate inputs (2**N_IN vectors)
//   TRUTH   expected output, bit i = expected y for input vector i
//   SETTLE  wait cycles between applying a vector and sampling (0 allowed)
//   ERR_W   error counter width (saturating)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured only in IDLE or DONE)
//   dut_in     out  registered stimulus to the gate, MSB = first gate input
//   dut_out    in   gate output
//   busy       out  run in progress
//   done       out  run finished, held until next start or reset
//   pass       out  valid with done: no mismatches in the run
//   err_count  out  mismatch count, saturates at all-ones
//   fail_vec   out  first mismatching vector, 0 if none
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | drive current vector onto dut_in
// WAIT   | let the gate output settle for SETTLE cycles
// CHECK  | compare gate output, advance or finish
// DONE   | results valid, waiting for start

module gate_truth_checker #(
    parameter int                      N_IN   = 2,
    parameter logic [(1 << N_IN)-1:0]  TRUTH  = 4'b1001,
    parameter int                      SETTLE = 1,
    parameter int                      ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  fail_vec
);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [N_IN-1:0]  vec;
    logic [CNT_W-1:0] settle_cnt;

    logic             mismatch;
    logic [ERR_W-1:0] err_inc;
    logic             finish;

    // Case inequality so an X/Z gate output is flagged in simulation.
    always_comb begin
        mismatch = (dut_out !== TRUTH[vec]);
        err_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
        finish   = (vec == VEC_LAST) || (STOP_ON_FAIL && mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_APPLY;
                        vec       <= '0;
                        dut_in    <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_APPLY: begin
                    dut_in <= vec;
                    if (SETTLE == 0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= CNT_W'(SETTLE);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt <= CNT_W'(1)) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        // err_count is still zero only before the first miss.
                        if (err_count == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (finish) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= S_APPLY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
